// File: rtl/ledmatrix_scroller.sv
// ledmatrix_scroller: frame source for the 8x8 LED-matrix driver.
// Snapshots a wide column bitmap and slides an 8-column window across it at
// SCROLL_HZ. The window wraps at the end of the bitmap. Each window is
// published as a 64-bit frame.
//
// Ports:
//   in_clk      main clock (MAIN_CLK_HZ)
//   in_rst      asynchronous active-high reset
//   in_enable   1 = scroll on every tick, 0 = paused
//   in_step     one-cycle pulse: single frame step while paused
//   in_dir      0 = scroll left (pos increments), 1 = scroll right (pos decrements)
//   in_home     synchronous pulse: pos returns to 0, any in-progress build is dropped
//   in_bitmap   NUM_COLS columns of 8 rows; column k = in_bitmap[8k+7:8k]
//   out_bits    published frame; byte c = window column c, bit r = row r
//   out_strobe  one-cycle pulse in the first cycle a new out_bits is visible
//   out_busy    high while a frame is being built or published
//   out_pos     bitmap column currently shown in window column 0
module ledmatrix_scroller #(
  parameter int unsigned MAIN_CLK_HZ = 27_000_000,
  parameter int unsigned SCROLL_HZ   = 10,
  parameter int unsigned NUM_COLS    = 32,
  parameter int unsigned PW          = $clog2(NUM_COLS)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_enable,
  input  logic                  in_step,
  input  logic                  in_dir,
  input  logic                  in_home,
  input  logic [NUM_COLS*8-1:0] in_bitmap,
  output logic [63:0]           out_bits,
  output logic                  out_strobe,
  output logic                  out_busy,
  output logic [PW-1:0]         out_pos
);

  localparam int unsigned Div     = MAIN_CLK_HZ / SCROLL_HZ;
  localparam int unsigned DivW    = $clog2(Div);
  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [PW-1:0]   LastCol = PW'(NUM_COLS - 1);

  typedef enum logic [1:0] {StIdle, StBuild, StPublish} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q;
  logic [NUM_COLS*8-1:0] snap_q, snap_d;
  logic [63:0]           shadow_q, shadow_d;
  logic [63:0]           bits_q, bits_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [2:0]            col_q, col_d;
  logic                  strobe_q, strobe_d;

  logic                  tick;
  logic                  start;
  logic [PW-1:0]         idx_next;
  logic [PW-1:0]         pos_inc;
  logic [PW-1:0]         pos_dec;

  // Tick divider runs independently of enable so the scroll cadence stays fixed.
  assign tick = (div_q == DivLast);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign start = (tick & in_enable) | (in_step & ~in_enable);

  // Modulo arithmetic by compare-and-wrap only; NUM_COLS need not be a power of two.
  assign idx_next = (idx_q == LastCol) ? '0 : idx_q + 1'b1;
  assign pos_inc  = (pos_q == LastCol) ? '0 : pos_q + 1'b1;
  assign pos_dec  = (pos_q == '0) ? LastCol : pos_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    shadow_d = shadow_q;
    bits_d   = bits_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    col_d    = col_q;
    strobe_d = 1'b0;

    if (in_home) begin
      // Home wins over everything; a partial shadow is harmless since a new
      // build overwrites all eight bytes.
      pos_d   = '0;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            snap_d  = in_bitmap;
            idx_d   = pos_q;
            col_d   = 3'd0;
            state_d = StBuild;
          end
        end
        StBuild: begin
          shadow_d[{col_q, 3'b000} +: 8] = snap_q[{idx_q, 3'b000} +: 8];
          idx_d = idx_next;
          col_d = col_q + 3'd1;
          if (col_q == 3'd7) begin
            state_d = StPublish;
          end
        end
        StPublish: begin
          bits_d   = shadow_q;
          strobe_d = 1'b1;
          pos_d    = in_dir ? pos_dec : pos_inc;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      shadow_q <= '0;
      bits_q   <= '0;
      idx_q    <= '0;
      pos_q    <= '0;
      col_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
      bits_q   <= bits_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      col_q    <= col_d;
      strobe_q <= strobe_d;
    end
  end

  assign out_bits   = bits_q;
  assign out_strobe = strobe_q;
  assign out_busy   = (state_q != StIdle);
  assign out_pos    = pos_q;

endmodule

// File: tb/tb_ledmatrix_scroller.sv
// Bench for ledmatrix_scroller with DIV=20, NUM_COLS=8. A frame-level model
// predicts each frame as a window computed straight from the snapshot and pos.
module tb_ledmatrix_scroller;

  localparam int unsigned MAIN_CLK_HZ = 1000;
  localparam int unsigned SCROLL_HZ   = 50;
  localparam int unsigned NUM_COLS    = 8;
  localparam int unsigned PW          = 3;
  localparam int unsigned DIV         = MAIN_CLK_HZ / SCROLL_HZ;
  localparam int unsigned BMW         = NUM_COLS * 8;
  localparam logic [63:0] Ramp        = 64'h0807060504030201;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b1;
  logic            in_enable = 1'b0;
  logic            in_step = 1'b0;
  logic            in_dir = 1'b0;
  logic            in_home = 1'b0;
  logic [BMW-1:0]  in_bitmap = '0;
  logic [63:0]     out_bits;
  logic            out_strobe;
  logic            out_busy;
  logic [PW-1:0]   out_pos;

  ledmatrix_scroller #(
    .MAIN_CLK_HZ(MAIN_CLK_HZ),
    .SCROLL_HZ  (SCROLL_HZ),
    .NUM_COLS   (NUM_COLS),
    .PW         (PW)
  ) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_enable (in_enable),
    .in_step   (in_step),
    .in_dir    (in_dir),
    .in_home   (in_home),
    .in_bitmap (in_bitmap),
    .out_bits  (out_bits),
    .out_strobe(out_strobe),
    .out_busy  (out_busy),
    .out_pos   (out_pos)
  );

  always #5 in_clk = ~in_clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: cycle count since reset, job age (0 = no job, 1..9 busy).
  int          m_cnt;
  int          m_age;
  int          m_pos;
  logic [63:0] m_frame;
  logic [63:0] m_bits;
  bit          m_strobe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] window(input logic [BMW-1:0] bm, input int p);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < 8; c++) begin
      f[8*c +: 8] = bm[8*((p + c) % NUM_COLS) +: 8];
    end
    return f;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_age = 0; m_pos = 0; m_frame = '0; m_bits = '0; m_strobe = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bits"},   out_bits,   64'h0);
    chk({tag, "_strobe"}, out_strobe, 64'h0);
    chk({tag, "_busy"},   out_busy,   64'h0);
    chk({tag, "_pos"},    out_pos,    64'h0);
  endtask

  // Advance the model over one clock using the current inputs, clock the DUT,
  // then compare every output.
  task automatic cycle();
    bit tick;
    tick     = (m_cnt == DIV - 1);
    m_strobe = 0;
    if (in_home) begin
      m_pos = 0;
      m_age = 0;
    end else if (m_age == 0) begin
      if ((tick && in_enable) || (in_step && !in_enable)) begin
        m_frame = window(in_bitmap, m_pos);
        m_age   = 1;
      end
    end else if (m_age < 9) begin
      m_age++;
    end else begin
      m_bits   = m_frame;
      m_strobe = 1;
      m_pos    = in_dir ? (m_pos + NUM_COLS - 1) % NUM_COLS : (m_pos + 1) % NUM_COLS;
      m_age    = 0;
    end
    m_cnt = (m_cnt + 1) % DIV;
    @(posedge in_clk);
    #1;
    chk("strobe", out_strobe, m_strobe);
    chk("busy",   out_busy,   (m_age != 0));
    chk("pos",    out_pos,    m_pos);
    chk("bits",   out_bits,   m_bits);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset(input logic en, input logic dir, input logic [BMW-1:0] bm);
    in_rst = 1'b1; in_enable = en; in_dir = dir; in_bitmap = bm;
    in_step = 1'b0; in_home = 1'b0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  task automatic wait_strobe(input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cycle();
      if (out_strobe) seen = 1;
    end
    chk("strobe_within_bound", seen, 1);
  endtask

  int strobes;

  initial begin
    // First frames after reset, left scroll, then wrap through all 8 positions.
    apply_reset(1'b1, 1'b0, Ramp);
    run(28);
    chk("no_strobe_before_29", out_strobe, 0);
    run(1);
    chk("first_strobe", out_strobe, 1);
    chk("first_bits", out_bits, Ramp);
    chk("first_pos", out_pos, 1);
    run(20);
    chk("second_strobe", out_strobe, 1);
    chk("second_bits", out_bits, 64'h0108070605040302);
    for (int f = 3; f <= 8; f++) begin
      run(20);
      chk("wrap_pos", out_pos, f % NUM_COLS);
    end
    chk("wrap_bits", out_bits, 64'h0706050403020108);

    // Right scroll.
    apply_reset(1'b1, 1'b1, Ramp);
    run(29);
    chk("dir_first_bits", out_bits, Ramp);
    chk("dir_first_pos", out_pos, 7);
    run(20);
    chk("dir_second_bits", out_bits, 64'h0706050403020108);
    chk("dir_second_pos", out_pos, 6);

    // Pause, single step, step while busy.
    apply_reset(1'b0, 1'b0, Ramp);
    strobes = 0;
    repeat (100) begin cycle(); strobes += int'(out_strobe); end
    chk("pause_quiet", strobes, 0);
    in_step = 1'b1; cycle(); in_step = 1'b0;
    run(8);
    chk("step_not_early", out_strobe, 0);
    run(1);
    chk("step_strobe", out_strobe, 1);
    chk("step_bits", out_bits, Ramp);
    in_step = 1'b1; cycle(); in_step = 1'b0;
    run(3);
    in_step = 1'b1; cycle(); in_step = 1'b0;
    strobes = 0;
    repeat (30) begin cycle(); strobes += int'(out_strobe); end
    chk("step_busy_frames", strobes, 1);

    // Bitmap change in build cycle 3 must not leak into the current frame.
    apply_reset(1'b1, 1'b0, Ramp);
    run(22);
    in_bitmap = '1;
    run(7);
    chk("snap_strobe", out_strobe, 1);
    chk("snap_bits", out_bits, Ramp);
    run(20);
    chk("snap_next_bits", out_bits, 64'hFFFF_FFFF_FFFF_FFFF);

    // Home in build cycle 4.
    apply_reset(1'b1, 1'b0, Ramp);
    run(49);
    chk("home_pre_bits", out_bits, 64'h0108070605040302);
    run(14);
    chk("home_in_build", out_busy, 1);
    in_home = 1'b1; cycle(); in_home = 1'b0;
    chk("home_busy", out_busy, 0);
    chk("home_pos", out_pos, 0);
    chk("home_held_bits", out_bits, 64'h0108070605040302);
    chk("home_no_strobe", out_strobe, 0);
    wait_strobe(40);
    chk("home_next_bits", out_bits, Ramp);

    // Asynchronous reset mid-build.
    apply_reset(1'b1, 1'b0, Ramp);
    run(44);
    chk("rst_in_build", out_busy, 1);
    #3;
    in_rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    model_reset();
    repeat (2) @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    run(29);
    chk("rst_restart_bits", out_bits, Ramp);

    // Randomized control and data against the model.
    apply_reset(1'b1, 1'b0, Ramp);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) in_enable = ~in_enable;
      in_step = ($urandom_range(0, 7) == 0);
      in_home = ($urandom_range(0, 79) == 0);
      in_dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) in_bitmap = {$urandom, $urandom};
      cycle();
    end
    in_step = 1'b0;
    in_home = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ledmatrix_scroller.md
# ledmatrix_scroller

Frame source for the 8x8 LED-matrix path. It holds a snapshot of a wide column bitmap and slides an 8-column window across it at a programmable scroll rate, wrapping at the end. It publishes each window as a 64-bit frame that connects directly to the matrix driver's `in_bits` input. It replaces the free-running test counter in the matrix top level and adds pause, single-step, direction and home control.

## Interface
- `MAIN_CLK_HZ`, 27_000_000, frequency of `in_clk`.
- `SCROLL_HZ`, 10, scroll steps per second.
  - DIV = MAIN_CLK_HZ/SCROLL_HZ (integer division).
  - DIV ≥ 16 is required.
- `NUM_COLS`, 32, number of columns in the bitmap. Must be ≥ 8.
- `PW`, $clog2(NUM_COLS), width of the position output.

Ports:
- `in_clk`  in  1  main clock.
- `in_rst`  in  1  reset, asynchronous, active-high.
- `in_enable`  in  1  1 = scroll on every tick; 0 = paused.
- `in_step`  in  1  one-cycle pulse; requests a single frame step while paused.
- `in_dir`  in  1  0 = scroll left (position increments); 1 = scroll right (position decrements).
- `in_home`  in  1  synchronous pulse; position returns to 0.
- `in_bitmap`  in  NUM_COLS*8  bitmap. Column k is `in_bitmap[8k+7:8k]`; bit r is row r.
- `out_bits`  out  64  published frame. Byte c = window column c (column 0 leftmost); bit r of each byte = row r.
- `out_strobe`  out  1  one-cycle pulse in the first cycle a new `out_bits` is visible.
- `out_busy`  out  1  high while a frame is being built (BUILD or PUBLISH).
- `out_pos`  out  PW  bitmap column currently shown in window column 0.

## Operation
- Tick divider:
  - Free-runs from reset, counting 0..DIV-1.
  - `tick` is high in the cycle the count equals DIV-1; the count then wraps to 0.
  - The divider runs regardless of `in_enable`.
- FSM states: IDLE, BUILD, PUBLISH.
- IDLE → BUILD when `(tick & in_enable) | (in_step & ~in_enable)`.
  - On that edge, `in_bitmap` is copied into the snapshot register.
  - The column index `idx` is loaded with `pos`, and `c` is set to 0.
- BUILD, 8 cycles:
  - Each cycle, `shadow[8c+7:8c]` is loaded with snapshot column `idx`.
  - `idx` then advances as `idx = (idx == NUM_COLS-1) ? 0 : idx+1`; modulo arithmetic is done only by this compare-and-wrap, with no divider.
  - `c` increments each cycle. After c = 7, the FSM moves to PUBLISH.
- PUBLISH, 1 cycle:
  - `out_bits <= shadow` and `out_strobe <= 1`.
  - `pos` advances: if `in_dir`=0, `pos = (pos == NUM_COLS-1) ? 0 : pos+1`; if `in_dir`=1, `pos = (pos == 0) ? NUM_COLS-1 : pos-1`.
  - `in_dir` is sampled in the PUBLISH cycle.
  - The FSM returns to IDLE.
- The displayed frame always reflects `pos` before the advance. The first frame after reset shows columns 0..7.
- `in_home`:
  - In any state, `pos <= 0` and the FSM goes to IDLE.
  - An in-progress build is discarded: `out_bits` is unchanged and there is no strobe.
  - `in_home` has priority over the start condition and over PUBLISH.
- Ignored inputs:
  - A tick or step arriving in BUILD or PUBLISH is dropped, not queued.
  - `in_step` is ignored while `in_enable`=1.
- Changes to `in_bitmap` after the snapshot edge do not affect the frame being built.

## Timing
- Reset values:
  - `out_bits` = 0, `out_strobe` = 0, `out_busy` = 0, `out_pos` = 0.
  - FSM = IDLE; divider count = 0; snapshot and shadow = 0.
- Latency:
  - Start condition seen in cycle 0 (FSM in IDLE).
  - BUILD occupies cycles 1..8 and PUBLISH occupies cycle 9.
  - New `out_bits`, `out_strobe`=1 and the updated `out_pos` are visible in cycle 10.
  - The build takes 10 cycles from the start condition to the visible frame, so it always finishes before the next tick (DIV ≥ 16).
- `out_busy` is high in cycles 1..9.
- `out_strobe` is high for exactly one cycle per completed frame.
- Reset asserted mid-build: all state clears immediately; no strobe is issued.
- Steady-state enabled operation: exactly one frame per DIV cycles, with `out_pos` stepping by 1 (mod NUM_COLS).

## Test plan
Test parameters for all scenarios: MAIN_CLK_HZ=1000, SCROLL_HZ=50 (DIV=20), NUM_COLS=8.

- **Reset.** Set `in_bitmap` so that column k = k+1, `in_enable`=1, `in_dir`=0, then release reset.
  - First strobe at cycle 29: tick at cycle 19, plus 10 cycles of latency.
  - `out_bits` = 64'h0807060504030201 and `out_pos` = 1.
  - Next strobe 20 cycles later with `out_bits` = 64'h0108070605040302.
- **Wrap-around.** Run 8 frames left.
  - `out_pos` follows 1..7, then 0.
  - The 8th frame shows column 7 in byte 0 and column 6 in byte 7.
- **Direction.** Set `in_dir`=1 from reset.
  - First frame = 64'h0807060504030201 with `out_pos` = 7.
  - Second frame = 64'h0706050403020108.
- **Pause and step.** Set `in_enable`=0.
  - No strobe for 100 cycles.
  - A single `in_step` pulse gives exactly one strobe 10 cycles later.
  - An `in_step` pulse during `out_busy` produces no extra frame.
- **Snapshot isolation.** Change `in_bitmap` to all ones in cycle 3 of a build.
  - The current frame is unchanged.
  - The next frame is 64'hFFFFFFFFFFFFFFFF.
- **Home and reset mid-build.**
  - Pulse `in_home` in BUILD cycle 4: no strobe, `out_bits` is held, `out_pos` = 0, and the next frame shows columns 0..7.
  - Assert `in_rst` mid-build: all outputs read 0 immediately.
